alu_ctrl_stage: RTL and testbench
=================================

# alu_ctrl_stage

Instruction-to-ALU-control stage: accepts a 32-bit MIPS-style instruction over a valid/ready handshake and decodes it into the 5-bit `alu_operation` code, operand-select bits and extended immediate consumed by the ALU. The decoded bundle is held in a single registered pipeline slot between fetch and execute. The slot supports stall via backpressure and flush, and carries an illegal-instruction flag and a saturating illegal counter for debug.

## Interface
- `XLEN`, 32: datapath width; `imm_ext` width.
- `CNT_W`, 8: width of `illegal_count`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: discard the held slot and any same-cycle input.
- `in_valid` in 1: `instr` valid.
- `in_ready` out 1: slot can accept this cycle.
- `instr` in 32: opcode[31:26], rs[25:21], rt[20:16], shamt[10:6], funct[5:0], imm[15:0].
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute consumes the bundle.
- `alu_operation` out 5: ALU op code.
- `op_a_sel` out 1: 0 = rs register, 1 = zero-extended shamt.
- `op_b_sel` out 1: 0 = rt register, 1 = `imm_ext`.
- `imm_ext` out XLEN: sign- or zero-extended imm[15:0].
- `illegal` out 1: held instruction was undecodable. The op is forced to NOP.
- `illegal_count` out CNT_W: saturating count of accepted illegal instructions.

## Operation
- Op codes: NOP=0, XOR=1, OR=2, AND=3, NOR=4, SLL=5, SRL=6, SLT=7, ADD=8, ADDU=9, SUB=10, SUBU=11, MULT=12, DIV=13, SRA=14, LUI=15.
- Operand convention: for shifts, the ALU shifts input2 (rt) by input1. Immediate shifts therefore set `op_a_sel`=1. Variable shifts set `op_a_sel`=0.
- R-type decode (opcode 0x00), `op_b_sel`=0:
  - funct 00 → SLL, 02 → SRL, 03 → SRA (all `op_a_sel`=1).
  - funct 04 → SLL, 06 → SRL, 07 → SRA.
  - funct 18 → MULT, 1A → DIV.
  - funct 20 → ADD, 21 → ADDU, 22 → SUB, 23 → SUBU.
  - funct 24 → AND, 25 → OR, 26 → XOR, 27 → NOR, 2A → SLT.
- I-type decode:
  - `op_b_sel`=1 with sign extension: 08 → ADD, 09 → ADDU, 0A → SLT, 23 (LW) → ADD, 2B (SW) → ADD.
  - `op_b_sel`=1 with zero extension: 0C → AND, 0D → OR, 0E → XOR.
  - 0F → LUI with `op_b_sel`=1. The extension choice is irrelevant; use zero.
  - 04 / 05 (BEQ/BNE) → SUB with `op_b_sel`=0.
- Any other opcode or funct: `alu_operation`=NOP, both selects 0, `illegal`=1.
- `imm_ext` is always computed per the extension rule above, including for R-type.
- Slot rules:
  - `in_ready` = !`out_valid` | `out_ready`.
  - A load occurs when `in_valid` & `in_ready` & !`flush`.
  - Load with consume in the same cycle: the new bundle replaces the old one.
  - Consume with no load: `out_valid` goes to 0.
  - `flush`: `out_valid` goes to 0 next edge and the input is dropped, regardless of the handshake.
- `illegal_count` increments on a load of an illegal instruction and saturates at all-ones. `flush` does not decrement it.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N is visible with `out_valid`=1 after edge N.
- Throughput is 1 per cycle while `out_ready`=1.
- Under stall (`out_valid`=1, `out_ready`=0), all outputs are held stable.
- Reset values: `out_valid`=0, `alu_operation`=NOP, `op_a_sel`=0, `op_b_sel`=0, `imm_ext`=0, `illegal`=0, `illegal_count`=0.
- `in_ready`=1 during and immediately after reset.
- Reset mid-stall discards the slot. There is no state machine beyond the valid bit and the counter.

## Structure
- `alu_pkg`: 5-bit op-code localparams (matching the values above), opcode and funct constants, and a decoded-bundle struct (op, a_sel, b_sel, imm, illegal).
- `alu_decode`: purely combinational sub-module, instr → bundle.
- `alu_ctrl_stage`: the slot register, handshake, flush and counter.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → all outputs read reset values at once; `in_ready`=1.
- `0x00A63020` (ADD r6,r5,r6) with `out_ready`=1 → next cycle `out_valid`=1, `alu_operation`=8, selects 0/0.
- `0x2008FFFF` (ADDI) → op=8, `op_b_sel`=1, `imm_ext`=0xFFFFFFFF. Then `0x3408FFFF` (ORI) → op=2, `imm_ext`=0x0000FFFF.
- `0x00084080` (SLL shamt 2) → op=5, `op_a_sel`=1. Then `0x3C081234` (LUI) → op=15, `op_b_sel`=1, `imm_ext`=0x00001234.
- Stall: hold `out_ready`=0 for 3 cycles → `in_ready`=0 and outputs stable. Raise `out_ready` with a new input → back-to-back transfer with no bubble.
- Illegal and flush:
  - Send opcode 0x3F 260 times with CNT_W=8 → `illegal`=1, op=0, `illegal_count` saturates at 255.
  - Assert `flush` with `in_valid`=1 → `out_valid`=0 next cycle and the count is unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes, MIPS opcode/funct constants and the decoded control bundle
// passed from the instruction decoder to the pipeline slot.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_XOR  = 5'd1;
    localparam logic [4:0] ALU_OR   = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_NOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SLT  = 5'd7;
    localparam logic [4:0] ALU_ADD  = 5'd8;
    localparam logic [4:0] ALU_ADDU = 5'd9;
    localparam logic [4:0] ALU_SUB  = 5'd10;
    localparam logic [4:0] ALU_SUBU = 5'd11;
    localparam logic [4:0] ALU_MULT = 5'd12;
    localparam logic [4:0] ALU_DIV  = 5'd13;
    localparam logic [4:0] ALU_SRA  = 5'd14;
    localparam logic [4:0] ALU_LUI  = 5'd15;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [4:0]          op;
        logic                a_sel;
        logic                b_sel;
        logic [XLEN_DEF-1:0] imm;
        logic                illegal;
    } alu_bundle_t;

    localparam alu_bundle_t BUNDLE_RST = '{op: ALU_NOP, a_sel: 1'b0, b_sel: 1'b0,
                                           imm: {XLEN_DEF{1'b0}}, illegal: 1'b0};

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS instruction decoder producing the ALU control bundle.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output alu_bundle_t bundle_o
);

    logic [5:0]  opc_s;
    logic [5:0]  fn_s;
    logic        zext_s;
    logic        unused_rs_rt_s;

    assign opc_s          = instr_i[31:26];
    assign fn_s           = instr_i[5:0];
    assign unused_rs_rt_s = ^instr_i[25:16];

    // Logical immediates and LUI zero-extend; everything else sign-extends.
    assign zext_s = (opc_s == OPC_ANDI) || (opc_s == OPC_ORI) ||
                    (opc_s == OPC_XORI) || (opc_s == OPC_LUI);

    // Opcode/funct decode; undecodable encodings keep NOP and zero selects.
    always_comb begin
        bundle_o         = BUNDLE_RST;
        bundle_o.imm     = zext_s ? {16'h0000, instr_i[15:0]}
                                  : {{16{instr_i[15]}}, instr_i[15:0]};
        case (opc_s)
            OPC_RTYPE: begin
                case (fn_s)
                    FN_SLL:  begin bundle_o.op = ALU_SLL; bundle_o.a_sel = 1'b1; end
                    FN_SRL:  begin bundle_o.op = ALU_SRL; bundle_o.a_sel = 1'b1; end
                    FN_SRA:  begin bundle_o.op = ALU_SRA; bundle_o.a_sel = 1'b1; end
                    FN_SLLV: bundle_o.op = ALU_SLL;
                    FN_SRLV: bundle_o.op = ALU_SRL;
                    FN_SRAV: bundle_o.op = ALU_SRA;
                    FN_MULT: bundle_o.op = ALU_MULT;
                    FN_DIV:  bundle_o.op = ALU_DIV;
                    FN_ADD:  bundle_o.op = ALU_ADD;
                    FN_ADDU: bundle_o.op = ALU_ADDU;
                    FN_SUB:  bundle_o.op = ALU_SUB;
                    FN_SUBU: bundle_o.op = ALU_SUBU;
                    FN_AND:  bundle_o.op = ALU_AND;
                    FN_OR:   bundle_o.op = ALU_OR;
                    FN_XOR:  bundle_o.op = ALU_XOR;
                    FN_NOR:  bundle_o.op = ALU_NOR;
                    FN_SLT:  bundle_o.op = ALU_SLT;
                    default: bundle_o.illegal = 1'b1;
                endcase
            end
            OPC_ADDI, OPC_LW, OPC_SW: begin bundle_o.op = ALU_ADD;  bundle_o.b_sel = 1'b1; end
            OPC_ADDIU:                begin bundle_o.op = ALU_ADDU; bundle_o.b_sel = 1'b1; end
            OPC_SLTI:                 begin bundle_o.op = ALU_SLT;  bundle_o.b_sel = 1'b1; end
            OPC_ANDI:                 begin bundle_o.op = ALU_AND;  bundle_o.b_sel = 1'b1; end
            OPC_ORI:                  begin bundle_o.op = ALU_OR;   bundle_o.b_sel = 1'b1; end
            OPC_XORI:                 begin bundle_o.op = ALU_XOR;  bundle_o.b_sel = 1'b1; end
            OPC_LUI:                  begin bundle_o.op = ALU_LUI;  bundle_o.b_sel = 1'b1; end
            OPC_BEQ, OPC_BNE:         bundle_o.op = ALU_SUB;
            default:                  bundle_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Single-slot pipeline register between fetch and execute holding the decoded
// ALU control bundle, with valid/ready backpressure, flush and an illegal counter.
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       alu_operation,
    output logic             op_a_sel,
    output logic             op_b_sel,
    output logic [XLEN-1:0]  imm_ext,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    alu_bundle_t      dec_s;
    alu_bundle_t      slot_q, slot_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_s;

    alu_decode u_decode (
        .instr_i  (instr),
        .bundle_o (dec_s)
    );

    assign in_ready = !valid_q || out_ready;
    assign load_s   = in_valid && in_ready && !flush;

    // Slot next-state: flush dominates, then load, then consume drains the slot.
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d = 1'b1;
            slot_d  = dec_s;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (load_s && dec_s.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Slot, valid bit and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            slot_q  <= BUNDLE_RST;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign alu_operation = slot_q.op;
    assign op_a_sel      = slot_q.a_sel;
    assign op_b_sel      = slot_q.b_sel;
    assign imm_ext       = slot_q.imm;
    assign illegal       = slot_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: expected bundles are queued on load and
// compared while the slot presents them; handshake and counter are modelled too.
module tb_alu_ctrl_stage;

    typedef struct packed {
        logic [4:0]  op;
        logic        a;
        logic        b;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  alu_operation;
    logic        op_a_sel;
    logic        op_b_sel;
    logic [31:0] imm_ext;
    logic        illegal;
    logic [7:0]  illegal_count;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic mvalid = 1'b0;
    logic [7:0] cnt_exp = 8'd0;

    localparam logic [31:0] I_ADD  = 32'h00A63020;
    localparam logic [31:0] I_ADDI = 32'h2008FFFF;
    localparam logic [31:0] I_ORI  = 32'h3408FFFF;
    localparam logic [31:0] I_SLL  = 32'h00084080;
    localparam logic [31:0] I_LUI  = 32'h3C081234;
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    alu_ctrl_stage #(.XLEN(32), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_operation (alu_operation),
        .op_a_sel      (op_a_sel),
        .op_b_sel      (op_b_sel),
        .imm_ext       (imm_ext),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] ins);
        exp_t       r;
        logic [5:0] opc;
        logic [5:0] fn;
        opc = ins[31:26];
        fn  = ins[5:0];
        r   = '0;
        if (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E || opc == 6'h0F)
            r.imm = {16'h0000, ins[15:0]};
        else
            r.imm = {{16{ins[15]}}, ins[15:0]};
        case (opc)
            6'h00: begin
                case (fn)
                    6'h00: begin r.op = 5'd5;  r.a = 1'b1; end
                    6'h02: begin r.op = 5'd6;  r.a = 1'b1; end
                    6'h03: begin r.op = 5'd14; r.a = 1'b1; end
                    6'h04: r.op = 5'd5;
                    6'h06: r.op = 5'd6;
                    6'h07: r.op = 5'd14;
                    6'h18: r.op = 5'd12;
                    6'h1A: r.op = 5'd13;
                    6'h20: r.op = 5'd8;
                    6'h21: r.op = 5'd9;
                    6'h22: r.op = 5'd10;
                    6'h23: r.op = 5'd11;
                    6'h24: r.op = 5'd3;
                    6'h25: r.op = 5'd2;
                    6'h26: r.op = 5'd1;
                    6'h27: r.op = 5'd4;
                    6'h2A: r.op = 5'd7;
                    default: r.ill = 1'b1;
                endcase
            end
            6'h08, 6'h23, 6'h2B: begin r.op = 5'd8;  r.b = 1'b1; end
            6'h09:               begin r.op = 5'd9;  r.b = 1'b1; end
            6'h0A:               begin r.op = 5'd7;  r.b = 1'b1; end
            6'h0C:               begin r.op = 5'd3;  r.b = 1'b1; end
            6'h0D:               begin r.op = 5'd2;  r.b = 1'b1; end
            6'h0E:               begin r.op = 5'd1;  r.b = 1'b1; end
            6'h0F:               begin r.op = 5'd15; r.b = 1'b1; end
            6'h04, 6'h05:        r.op = 5'd10;
            default:             r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // One cycle: drive inputs at the falling edge, check current outputs, advance model.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        exp_t e;
        logic ld;
        logic fire;
        in_valid  = v;
        instr     = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
        chk("in_ready", {31'b0, in_ready}, {31'b0, (!mvalid || ordy)});
        chk("illegal_count", {24'b0, illegal_count}, {24'b0, cnt_exp});
        if (mvalid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb[0];
                chk("alu_operation", {27'b0, alu_operation}, {27'b0, e.op});
                chk("op_a_sel", {31'b0, op_a_sel}, {31'b0, e.a});
                chk("op_b_sel", {31'b0, op_b_sel}, {31'b0, e.b});
                chk("imm_ext", imm_ext, e.imm);
                chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
            end
        end
        fire = mvalid && ordy;
        ld   = v && (!mvalid || ordy) && !fl;
        if (fl) begin
            if (mvalid && sb.size() > 0) void'(sb.pop_front());
            mvalid = 1'b0;
        end else begin
            if (fire && sb.size() > 0) void'(sb.pop_front());
            if (ld) begin
                e = ref_dec(ins);
                sb.push_back(e);
                if (e.ill && cnt_exp != 8'hFF) cnt_exp = cnt_exp + 8'd1;
            end
            mvalid = ld || (mvalid && !ordy);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_op"}, {27'b0, alu_operation}, 32'd0);
        chk({tag, "_a_sel"}, {31'b0, op_a_sel}, 32'd0);
        chk({tag, "_b_sel"}, {31'b0, op_b_sel}, 32'd0);
        chk({tag, "_imm"}, imm_ext, 32'd0);
        chk({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
        chk({tag, "_cnt"}, {24'b0, illegal_count}, 32'd0);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    // Asynchronous reset applied mid-cycle, checked immediately and after an edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        sb.delete();
        mvalid  = 1'b0;
        cnt_exp = 8'd0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rnd;
        @(negedge clk);
        apply_reset();

        step(1'b1, I_ADD, 1'b1, 1'b0);
        chk("add_op", {27'b0, alu_operation}, 32'd8);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        step(1'b1, I_ADDI, 1'b1, 1'b0);
        chk("addi_imm", imm_ext, 32'hFFFFFFFF);
        step(1'b1, I_ORI, 1'b1, 1'b0);
        chk("ori_imm", imm_ext, 32'h0000FFFF);
        step(1'b1, I_SLL, 1'b1, 1'b0);
        chk("sll_a_sel", {31'b0, op_a_sel}, 32'd1);
        step(1'b1, I_LUI, 1'b1, 1'b0);
        chk("lui_op", {27'b0, alu_operation}, 32'd15);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall for three cycles then resume back-to-back.
        step(1'b1, I_ADDI, 1'b1, 1'b0);
        step(1'b1, I_ORI, 1'b0, 1'b0);
        step(1'b1, I_ORI, 1'b0, 1'b0);
        step(1'b1, I_ORI, 1'b0, 1'b0);
        chk("stall_held_imm", imm_ext, 32'hFFFFFFFF);
        step(1'b1, I_ORI, 1'b1, 1'b0);
        step(1'b1, I_LUI, 1'b1, 1'b0);
        chk("no_bubble_imm", imm_ext, 32'h00001234);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomised traffic with mixed legal/illegal encodings.
        for (int i = 0; i < 60; i++) begin
            rnd = $urandom;
            if ($urandom_range(0, 1) == 0) rnd[31:26] = 6'h00;
            step(1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 9) == 0));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset while stalled discards the slot.
        step(1'b1, I_ADD, 1'b0, 1'b0);
        step(1'b1, I_ORI, 1'b0, 1'b0);
        apply_reset();

        // Flush with a same-cycle input drops both; count unchanged.
        step(1'b1, I_ILL, 1'b1, 1'b0);
        chk("ill_flag", {31'b0, illegal}, 32'd1);
        chk("ill_op", {27'b0, alu_operation}, 32'd0);
        step(1'b1, I_ILL, 1'b0, 1'b1);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_cnt", {24'b0, illegal_count}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Counter saturation.
        for (int i = 0; i < 260; i++) step(1'b1, I_ILL, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("cnt_sat", {24'b0, illegal_count}, 32'd255);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
